// File: rtl/la_readout_ctrl.sv
// Capture controller and readout streamer for the logic_analyzer delay-line sampler.
// Triggers a capture, latches the snapshot array, then streams entries oldest first.
module la_readout_ctrl #(
  parameter int unsigned ENTRY_LENGTH = 16,
  parameter int unsigned NUM_ENTRY    = 15,
  parameter int unsigned TRIG_WIDTH   = 4,
  parameter int unsigned TIMEOUT      = 255,
  localparam int unsigned IW = $clog2(NUM_ENTRY),
  localparam int unsigned PW = $clog2(ENTRY_LENGTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   nrst,
  input  logic                                   start,
  output logic                                   trig_begin,
  input  logic                                   trig_end,
  input  logic [NUM_ENTRY-1:0][ENTRY_LENGTH-1:0] snap_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ENTRY_LENGTH-1:0]                out_data,
  output logic [IW-1:0]                          out_index,
  output logic [PW-1:0]                          out_ones,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   timeout,
  output logic                                   overrun
);

  localparam int unsigned AW = $clog2(TRIG_WIDTH + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StArm, StWait, StDrain} state_e;

  state_e                                 state_q, state_d;
  logic [AW-1:0]                          arm_q, arm_d;
  logic [WW-1:0]                          wdog_q, wdog_d;
  logic [IW-1:0]                          idx_q, idx_d;
  logic [NUM_ENTRY-1:0][ENTRY_LENGTH-1:0] snap_q, snap_d;
  logic                                   trig_q, trig_d;
  logic                                   valid_q, valid_d;
  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;
  logic                                   timeout_q, timeout_d;
  logic                                   overrun_q, overrun_d;
  logic                                   capture;
  logic [ENTRY_LENGTH-1:0]                cur_entry;
  logic [PW-1:0]                          ones;

  always_comb begin
    state_d   = state_q;
    arm_d     = arm_q;
    wdog_d    = wdog_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    trig_d    = trig_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    capture   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          timeout_d = 1'b0;
          overrun_d = 1'b0;
          arm_d     = AW'(TRIG_WIDTH);
          state_d   = StArm;
        end
      end
      StArm: begin
        // An early end pulse still captures; the arm window is simply cut short.
        if (trig_end) begin
          capture = 1'b1;
        end else if (arm_q != '0) begin
          trig_d = 1'b1;
          arm_d  = arm_q - 1'b1;
        end else begin
          trig_d  = 1'b0;
          wdog_d  = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (trig_end) begin
          capture = 1'b1;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StDrain: begin
        if (trig_end) begin
          overrun_d = 1'b1;
        end
        if (valid_q && out_ready) begin
          if (idx_q == '0) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      snap_d  = snap_in;
      idx_d   = IW'(NUM_ENTRY - 1);
      trig_d  = 1'b0;
      valid_d = 1'b1;
      state_d = StDrain;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StIdle;
      arm_q     <= '0;
      wdog_q    <= '0;
      idx_q     <= '0;
      snap_q    <= '0;
      trig_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      wdog_q    <= wdog_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      trig_q    <= trig_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign cur_entry = snap_q[idx_q];

  always_comb begin
    ones = '0;
    for (int i = 0; i < ENTRY_LENGTH; i++) begin
      ones = ones + PW'(cur_entry[i]);
    end
  end

  assign trig_begin = trig_q;
  assign out_valid  = valid_q;
  assign out_data   = cur_entry;
  assign out_index  = idx_q;
  assign out_ones   = ones;
  // Gated by valid so the reset/idle value is 0 even though idx rests at 0.
  assign out_last   = valid_q && (idx_q == '0);
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_la_readout_ctrl.sv
// Self-checking bench for la_readout_ctrl: arm-sequence vector table plus
// scoreboarded capture/drain scenarios.
module tb_la_readout_ctrl;

  localparam int EL = 16;
  localparam int NE = 15;
  localparam int TW = 4;
  localparam int TO = 255;

  logic                   clk;
  logic                   nrst;
  logic                   start;
  logic                   trig_begin;
  logic                   trig_end;
  logic [NE-1:0][EL-1:0]  snap_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [EL-1:0]          out_data;
  logic [3:0]             out_index;
  logic [4:0]             out_ones;
  logic                   out_last;
  logic                   busy;
  logic                   done;
  logic                   timeout;
  logic                   overrun;

  la_readout_ctrl #(
    .ENTRY_LENGTH(EL),
    .NUM_ENTRY   (NE),
    .TRIG_WIDTH  (TW),
    .TIMEOUT     (TO)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .trig_begin(trig_begin),
    .trig_end  (trig_end),
    .snap_in   (snap_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_ones  (out_ones),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [EL-1:0] data;
    logic [3:0]    idx;
    logic [4:0]    ones;
    logic          last;
  } beat_t;

  typedef struct {
    logic start;
    logic te;
    logic exp_tb;
    logic exp_busy;
    logic exp_ov;
  } vec_t;

  beat_t         sb[$];
  vec_t          tbl[8];
  int            n_vec = 0;
  int            n_err = 0;
  int            nbeats = 0;
  int            done_cnt = 0;
  int            cyc;
  int            base;
  logic          hold_v = 1'b0;
  logic [EL-1:0] hold_data;
  logic [3:0]    hold_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push_snap();
    for (int i = NE - 1; i >= 0; i--) begin
      beat_t b;
      b.data = snap_in[i];
      b.idx  = 4'(i);
      b.ones = 5'($countones(snap_in[i]));
      b.last = (i == 0);
      sb.push_back(b);
    end
  endtask

  task automatic fire_trig();
    trig_end = 1'b1;
    push_snap();
    step();
    trig_end = 1'b0;
  endtask

  task automatic rand_snap();
    for (int k = 0; k < NE; k++) snap_in[k] = 16'($urandom);
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
  task automatic drain(input int mode, input int bound, output int ncyc);
    int d0;
    d0   = done_cnt;
    ncyc = 0;
    while (ncyc < bound) begin
      out_ready = (mode == 0) ? 1'b1 : ((ncyc % 3) == 0);
      step();
      ncyc++;
      if (done) break;
    end
    chk("done_seen", done, 1);
    out_ready = 1'b1;
    step();
    chk("done_width", done, 0);
    chk("done_count", done_cnt, d0 + 1);
    chk("sb_drained", sb.size(), 0);
    chk("busy_after_drain", busy, 0);
    sb.delete();
  endtask

  // Output monitor: pops the scoreboard on every accepted beat, checks hold stability.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (out_valid) begin
        if (hold_v) begin
          chk("hold_data", out_data, hold_data);
          chk("hold_index", out_index, hold_idx);
        end
        if (out_ready) begin
          chk("beat_expected", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("beat_data", out_data, e.data);
            chk("beat_index", out_index, e.idx);
            chk("beat_ones", out_ones, e.ones);
            chk("beat_last", out_last, e.last);
          end
          nbeats++;
          hold_v = 1'b0;
        end else begin
          hold_v    = 1'b1;
          hold_data = out_data;
          hold_idx  = out_index;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    tbl[0] = '{start: 1'b0, te: 1'b1, exp_tb: 1'b0, exp_busy: 1'b0, exp_ov: 1'b0};
    tbl[1] = '{start: 1'b1, te: 1'b0, exp_tb: 1'b0, exp_busy: 1'b1, exp_ov: 1'b0};
    tbl[2] = '{start: 1'b0, te: 1'b0, exp_tb: 1'b1, exp_busy: 1'b1, exp_ov: 1'b0};
    tbl[3] = '{start: 1'b0, te: 1'b0, exp_tb: 1'b1, exp_busy: 1'b1, exp_ov: 1'b0};
    tbl[4] = '{start: 1'b0, te: 1'b0, exp_tb: 1'b1, exp_busy: 1'b1, exp_ov: 1'b0};
    tbl[5] = '{start: 1'b0, te: 1'b0, exp_tb: 1'b1, exp_busy: 1'b1, exp_ov: 1'b0};
    tbl[6] = '{start: 1'b0, te: 1'b0, exp_tb: 1'b0, exp_busy: 1'b1, exp_ov: 1'b0};
    tbl[7] = '{start: 1'b0, te: 1'b0, exp_tb: 1'b0, exp_busy: 1'b1, exp_ov: 1'b0};

    nrst = 1'b0; start = 1'b0; trig_end = 1'b0; out_ready = 1'b1; snap_in = '0;
    #12;
    chk("rst_trig_begin", trig_begin, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_ones", out_ones, 0);
    @(negedge clk);
    nrst = 1'b1;
    step();

    // Arm sequence: idle trig_end ignored, then start and a TW-cycle trigger pulse.
    for (int r = 0; r < 8; r++) begin
      start    = tbl[r].start;
      trig_end = tbl[r].te;
      step();
      chk($sformatf("vec%0d_trig_begin", r), trig_begin, tbl[r].exp_tb);
      chk($sformatf("vec%0d_busy", r), busy, tbl[r].exp_busy);
      chk($sformatf("vec%0d_out_valid", r), out_valid, tbl[r].exp_ov);
      chk($sformatf("vec%0d_overrun", r), overrun, 0);
    end
    start = 1'b0; trig_end = 1'b0;

    // trig_end sampled 20 edges after start; ramp pattern, ready held high.
    repeat (13) step();
    for (int k = 0; k < NE; k++) snap_in[k] = 16'((1 << k) - 1);
    base = nbeats;
    fire_trig();
    chk("first_valid", out_valid, 1);
    chk("first_index", out_index, NE - 1);
    chk("first_ones", out_ones, NE - 1);
    drain(0, 40, cyc);
    chk("ramp_cycles", cyc, NE);
    chk("ramp_beats", nbeats - base, NE);

    // Ready toggling 1,0,0; snapshot input scrambled after capture.
    do_start();
    repeat (10) step();
    rand_snap();
    base = nbeats;
    fire_trig();
    rand_snap();
    drain(1, 200, cyc);
    chk("toggle_beats", nbeats - base, NE);

    // Watchdog abort, then terminal-count tie where trig_end wins.
    base = nbeats;
    do_start();
    cyc = 0;
    while (!timeout && cyc < 400) begin
      step();
      cyc++;
    end
    chk("timeout_latency", cyc, TW + 1 + TO);
    chk("timeout_busy", busy, 0);
    chk("timeout_trig_begin", trig_begin, 0);
    chk("timeout_no_beats", nbeats - base, 0);
    do_start();
    chk("timeout_cleared", timeout, 0);
    chk("restart_busy", busy, 1);
    repeat (TW + TO) step();
    rand_snap();
    fire_trig();
    chk("tie_no_timeout", timeout, 0);
    chk("tie_capture", out_valid, 1);
    drain(0, 40, cyc);

    // Overrun: trig_end and start mid-drain must not disturb the stream.
    do_start();
    repeat (8) step();
    rand_snap();
    fire_trig();
    out_ready = 1'b1;
    repeat (5) step();
    rand_snap();
    trig_end = 1'b1;
    start    = 1'b1;
    step();
    trig_end = 1'b0;
    start    = 1'b0;
    chk("overrun_set", overrun, 1);
    drain(0, 40, cyc);
    step();
    chk("overrun_sticky", overrun, 1);
    chk("start_ignored_busy", busy, 0);
    chk("start_ignored_trig", trig_begin, 0);
    do_start();
    chk("overrun_cleared", overrun, 0);

    // Asynchronous reset partway through a drain.
    repeat (6) step();
    rand_snap();
    fire_trig();
    base = nbeats;
    out_ready = 1'b1;
    cyc = 0;
    while ((nbeats - base) < 7 && cyc < 40) begin
      trig_end = (cyc == 2);
      step();
      cyc++;
    end
    trig_end = 1'b0;
    chk("pre_reset_overrun", overrun, 1);
    chk("pre_reset_valid", out_valid, 1);
    #2 nrst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_trig_begin", trig_begin, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_timeout", timeout, 0);
    chk("arst_done", done, 0);
    chk("arst_out_last", out_last, 0);
    sb.delete();
    @(negedge clk);
    nrst = 1'b1;
    step();

    // Fresh capture after reset completes a full drain.
    do_start();
    repeat (12) step();
    rand_snap();
    base = nbeats;
    fire_trig();
    drain(0, 40, cyc);
    chk("post_reset_beats", nbeats - base, NE);
    chk("post_reset_cycles", cyc, NE);

    // trig_end during ARM captures and drops trig_begin.
    do_start();
    step();
    chk("arm_trig_high", trig_begin, 1);
    rand_snap();
    fire_trig();
    chk("arm_capture_trig_low", trig_begin, 0);
    chk("arm_capture_valid", out_valid, 1);
    drain(0, 40, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/la_readout_ctrl.md
# la_readout_ctrl

Control and readout stage for the `logic_analyzer` delay-line sampler, instantiated alongside it.
- On a software `start`, it issues a trigger pulse to the analyzer and waits for the analyzer's end-of-capture pulse.
- It then latches the full snapshot array and streams it out one entry per handshake, oldest entry first, tagging each entry with its index and popcount (the delay-line edge depth).
- A watchdog covers a missing end pulse, and sticky flags report timeout and overrun.

## Interface
Parameters:
- ENTRY_LENGTH, 16, bits per snapshot entry.
- NUM_ENTRY, 15, number of snapshot entries. Must be ≥2.
- TRIG_WIDTH, 4, number of cycles `trig_begin` is held high. Must be ≥1.
- TIMEOUT, 255, maximum number of WAIT cycles before abort. Must be ≥1.

Derived widths:
- IW = $clog2(NUM_ENTRY), which is 4 at defaults.
- PW = $clog2(ENTRY_LENGTH+1), which is 5 at defaults.

Ports:
- clk  in  1  single clock; all state on posedge.
- nrst  in  1  reset, asynchronous, active-low.
- start  in  1  request a capture. Honoured only in IDLE.
- trig_begin  out  1  trigger to the analyzer. Registered.
- trig_end  in  1  analyzer end-of-capture pulse, synchronous to clk.
- snap_in  in  [ENTRY_LENGTH-1:0] x [NUM_ENTRY-1:0]  analyzer snapshot array. Index 0 is the newest entry.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream ready.
- out_data  out  ENTRY_LENGTH  snapshot entry.
- out_index  out  IW  index of the entry within snap_in.
- out_ones  out  PW  number of 1 bits in out_data.
- out_last  out  1  high with entry 0.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last entry is accepted.
- timeout  out  1  sticky; set on watchdog abort.
- overrun  out  1  sticky; set on a trig_end arriving during DRAIN.

## Operation
- Reset values: state IDLE; every output is 0; the snapshot buffer, the index counter and the watchdog counter are 0.
- IDLE:
  - `start`=1 at an edge clears `timeout` and `overrun`, loads the arm counter, and moves to ARM.
  - trig_end in IDLE is ignored, with no flag set.
- ARM:
  - `trig_begin`=1 for exactly TRIG_WIDTH cycles, then the block moves to WAIT and clears the watchdog counter.
  - A trig_end during ARM is honoured as it would be in WAIT: capture, drop trig_begin, go to DRAIN.
- WAIT:
  - The watchdog counter increments every cycle.
  - trig_end=1 copies all of snap_in into the internal buffer on that edge, sets the index counter to NUM_ENTRY-1, and moves to DRAIN.
  - If the counter reaches TIMEOUT-1 without trig_end, the block sets `timeout` and returns to IDLE. No data is streamed.
  - If trig_end and the timeout terminal count occur on the same edge, trig_end wins: capture, no timeout.
- DRAIN:
  - `out_valid`=1 continuously.
  - `out_data` = buffer[idx], `out_index` = idx, `out_ones` = popcount(buffer[idx]), `out_last` = (idx==0).
  - An entry transfers on an edge where out_valid&out_ready=1.
  - Outputs are held stable while out_ready=0.
  - After a transfer with idx>0, idx decrements.
  - After the transfer of idx==0: the next state is IDLE, out_valid drops, and `done` pulses for one cycle.
  - trig_end during DRAIN sets `overrun`. The buffer is not overwritten and the drain continues.
  - `start` during ARM, WAIT or DRAIN is ignored.
- Popcount is computed combinationally from the buffered entry, full width, with no saturation. Its maximum is ENTRY_LENGTH.
- Asserting nrst in any state returns the block asynchronously to its reset values. trig_begin and out_valid go low immediately, and any partial drain is discarded.

## Timing
- `start` sampled at edge N → trig_begin high after edges N+1 … N+TRIG_WIDTH, low after edge N+TRIG_WIDTH+1 → WAIT.
- trig_end sampled at edge M → out_valid high after M+1 with index NUM_ENTRY-1. The first transfer is possible at edge M+1.
- With out_ready held high: NUM_ENTRY transfers on consecutive edges M+1 … M+NUM_ENTRY. `done` is high for the cycle after edge M+NUM_ENTRY. The block returns to IDLE after edge M+NUM_ENTRY.
- Watchdog: abort after the TIMEOUT-th WAIT cycle. `timeout` is visible the cycle after.
- Earliest next accepted `start`: the edge after `done` or after the timeout abort.
- All outputs are registered, except out_data, out_index, out_ones and out_last, which are decoded from registered state and the buffer.

## Test plan
- Reset, then start=1 for 1 cycle → trig_begin high for exactly 4 cycles, busy=1, no out_valid.
- Drive trig_end 20 cycles after start with snap_in[k] = (1<<k)-1, out_ready=1 → 15 beats with indices 14…0 and out_ones 14…0. out_last only on index 0. done pulses once.
- Same capture with out_ready toggling 1,0,0,1,… → no beat lost or duplicated, outputs stable while out_ready=0. snap_in changed after capture does not affect the data.
- Omit trig_end → timeout=1 after 255 WAIT cycles, busy=0, no beats. The next start clears timeout.
- trig_end pulsed again mid-drain, plus start during DRAIN → overrun=1, stream completes unaltered, start ignored.
- nrst low at beat 7 → out_valid=0 and trig_begin=0 immediately, all flags 0. A fresh start then completes a normal 15-beat drain.
